// File: rtl/sub49_pkg.sv
// Shared types and sizing helpers for the multi-cycle 49-bit subtractor.
package sub49_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice count for an operand of width+1 bits taken chunk bits at a time.
    function automatic int nch(input int width, input int chunk);
        return (width + chunk) / chunk;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NCH_DEFAULT   = nch(48, 16);
    localparam int CNT_W_DEFAULT = cnt_w(NCH_DEFAULT);

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit ripple subtractor: d = a - b - bin, with borrow out.
module sub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             bin_i,
    output logic [CHUNK-1:0] d_o,
    output logic             bout_o
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic             br;

    assign g = ~a_i & b_i;
    assign p = ~(a_i ^ b_i);

    // NOTE: br is a scratch variable rippling through the loop, so it must use
    // blocking assignments; every output gets a default first so no latch forms.
    always_comb begin
        br  = bin_i;
        d_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            d_o[i] = a_i[i] ^ b_i[i] ^ br;
            br     = g[i] | (p[i] & br);
        end
        bout_o = br;
    end

endmodule

// File: rtl/sub49_seq.sv
// Multi-cycle unsigned subtractor: out = A - B mod 2^(WIDTH+1), one CHUNK slice
// per clock, least significant first, with valid/ready on both sides.
module sub49_seq
    import sub49_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int CHUNK = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:0] A,
    input  logic [WIDTH:0] B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] out,
    output logic           borrow
);

    localparam int NCH = nch(WIDTH, CHUNK);
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = cnt_w(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_e         state_q, state_d;
    logic [PW-1:0]  a_q, a_d;
    logic [PW-1:0]  b_q, b_d;
    logic [PW-1:0]  res_q, res_d;
    logic           bor_q, bor_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [CHUNK-1:0] diff;
    logic             bout;

    // Operands shift right each RUN cycle, so the live slice is always at bit 0.
    sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .bin_i  (bor_q),
        .d_o    (diff),
        .bout_o (bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = PW'(A);
                    b_d     = PW'(B);
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                // New slice enters at the top; after NCH shifts slice 0 sits at bit 0.
                res_d = (res_q >> CHUNK) | (PW'(diff) << (PW - CHUNK));
                bor_d = bout;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the operand and result registers are reset too, so out never shows X
    // and a reset mid-operation leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        if (PW > WIDTH + 1) begin : g_pad
            // Padding bits of the difference are discarded by design.
            logic unused_pad;
            assign unused_pad = ^res_q[PW-1:WIDTH+1];
        end
    endgenerate

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = res_q[WIDTH:0];
    assign borrow    = bor_q;

endmodule

// File: doc/sub49_seq.md
# sub49_seq

Multi-cycle 49-bit unsigned subtractor computing `out = A - B` (mod 2^(WIDTH+1)) with a borrow flag. It processes the operands in CHUNK-bit slices, least significant first, one slice per clock. It sits beside the combinational 49-bit adder in the modular-squaring datapath and provides the reduction/compare direction: subtracting the modulus and testing `A < B`. Valid/ready handshakes on both sides.

## Interface
Parameters:
- `WIDTH`, default 48: MSB index; operands and result are WIDTH+1 bits.
- `CHUNK`, default 16: bits subtracted per cycle, legal range 1..WIDTH+1.
- Derived constant: `NCH = ceil((WIDTH+1)/CHUNK)`, which is 4 at defaults.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `A` input WIDTH+1: minuend, unsigned.
- `B` input WIDTH+1: subtrahend, unsigned.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes result.
- `out` output WIDTH+1: `(A - B) mod 2^(WIDTH+1)`.
- `borrow` output 1: 1 iff A < B (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch A and B zero-extended to NCH*CHUNK bits, clear the borrow register, clear the chunk counter, go to RUN.
- RUN:
  - Each cycle, compute slice i as `diff = A[i] - B[i] - borrow_reg`.
  - Write the low CHUNK bits of `diff` into result slice i and store the outgoing borrow in `borrow_reg`.
  - Increment the counter; after slice NCH-1, go to DONE.
- DONE:
  - `out_valid`=1.
  - `out` is the result truncated to WIDTH+1 bits; `borrow` = `borrow_reg`.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` is ignored there and operands are not captured; no overlap or queueing.
- Padding bits above WIDTH are zero in both operands. The final borrow therefore equals the full-width borrow, and the padding bits of the difference are discarded.
- `out` and `borrow` are held stable throughout DONE regardless of `out_ready` wait length. Outside DONE their values are don't-care to consumers but must not be X.
- `in_ready` and `out_valid` are decoded from state registers only, with no combinational path from `in_valid`/`out_ready`.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, `borrow`=0, counter=0, `borrow_reg`=0.
- Latency: operands accepted at edge T; `out_valid` rises after edge T+NCH, i.e. 4 cycles at defaults.
- Minimum op spacing is NCH+2 cycles: accept, NCH RUN cycles, one DONE cycle with `out_ready`=1, then back in IDLE for the next accept.
- Reset mid-RUN or mid-DONE aborts the operation immediately. `out_valid` drops asynchronously and no result is delivered. Normal operation resumes on the first edge after `rst_n` deasserts.
- Degenerate CHUNK=WIDTH+1 (NCH=1): exactly one RUN cycle.
- Non-dividing CHUNK (e.g. 7 with WIDTH=48 gives NCH=7, 49 bits exact; 10 gives NCH=5, 1 padding bit): result must be correct.

## Structure
- Shared package `sub49_pkg`:
  - state enum {IDLE, RUN, DONE}
  - function `nch(width, chunk)` returning the ceiling slice count
  - counter width constant `$clog2(NCH)` with minimum 1.
- One sub-module `sub_chunk`: combinational CHUNK-bit ripple subtractor with `bin`/`bout`. It is the subtract counterpart of the adder's generate/propagate loop: `g = ~a & b`, `p = ~(a ^ b)`, `bout_i = g | (p & bin_i)`, `d_i = a ^ b ^ bin_i`.
- The top level holds the state FSM, the operand shift or index logic, the result register and the counter.

## Test plan
- A=0x1_0000_0000_0000, B=1 -> out=0x0_FFFF_FFFF_FFFF, borrow=0, `out_valid` exactly 4 cycles after the accept edge.
- A=0, B=1 -> out=0x1_FFFF_FFFF_FFFF, borrow=1. A=B=0x1_2345_6789_ABCD -> out=0, borrow=0.
- `out_ready` held low 10 cycles in DONE -> `out` and `borrow` stable, `in_ready`=0. A pulse of `in_valid` with new operands is ignored and the next result is unaffected.
- `rst_n` low during RUN slice 2 -> `out_valid`=0 immediately and `in_ready`=1. The following op A=5, B=3 -> out=2, borrow=0.
- Back-to-back ops with `in_valid` and `out_ready` tied high -> one accept every 6 cycles at defaults, each result matching the model.
- Parameter sweep CHUNK in {1, 7, 10, 16, 49}: 1000 random operand pairs plus corner values 0 and 2^49-1 against a golden A-B model, checking `out`, `borrow` and latency NCH.
